fifo_dc_read_port: RTL and testbench

- Read-side adapter for the team's dual-clock FIFO (non-showahead, 1-cycle read latency).
- Runs in the FIFO's read clock domain and drains the FIFO through its rdreq/q/rdempty port.
- Presents the words as a registered valid/ready stream to downstream GPU logic.
- Owns a small internal buffer so it sustains one word per clock without a combinational path from out_ready to fifo_rdreq.

---
 rtl/fifo_dc_read_port.sv | 53 +++++
 tb/tb_fifo_dc_read_port.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_dc_read_port.sv
// fifo_dc_read_port: drains a 1-cycle-latency FIFO into a registered valid/ready stream.
// A small circular buffer absorbs in-flight reads so rdreq never depends on out_ready.
module fifo_dc_read_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CNTW = 32,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic             fifo_rdempty,
  output logic             fifo_rdreq,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    occupancy,
  output logic [CNTW-1:0]  words_read
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic inflight, pop;
  logic [OW:0] level;
  assign pop = out_valid && out_ready;
  assign out_valid = occupancy != '0;
  assign out_data = mem[rd_ptr];
  // Count the word still on fifo_q so a read is only issued into guaranteed free space.
  assign level = {1'b0, occupancy} + (OW + 1)'(inflight);
  assign fifo_rdreq = !reset && !fifo_rdempty && level < (OW + 1)'(DEPTH);
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
      words_read <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      assert (!(inflight && !pop && occupancy == OW'(DEPTH)));
      inflight <= fifo_rdreq;
      if (inflight) begin
        mem[wr_ptr] <= fifo_q;
        wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        words_read <= words_read + CNTW'(1);
      end
      occupancy <= occupancy + OW'(inflight) - OW'(pop);
    end
  end
endmodule

// File: tb/tb_fifo_dc_read_port.sv
// tb_fifo_dc_read_port: random and directed checks against a queue-based FIFO/stream model.
module tb_fifo_dc_read_port;
  localparam int DEPTH = 3;
  logic clock = 0, reset = 1, fifo_rdempty = 1, out_ready = 0;
  logic [31:0] fifo_q = '0;
  logic fifo_rdreq, out_valid, rq4, v4;
  logic [31:0] out_data, d4, words_read;
  logic [1:0] occupancy, o4;
  logic [3:0] wr4;
  int compared = 0, mismatched = 0;
  logic [31:0] src[$], exq[$];
  int occ = 0, pres = 0, pops = 0;
  logic last_rq, last_v, last_pop;
  logic [31:0] last_d;

  fifo_dc_read_port #(.WIDTH(32), .DEPTH(DEPTH), .CNTW(32)) dut (
    .clock(clock), .reset(reset), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
    .fifo_rdreq(fifo_rdreq), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy), .words_read(words_read));
  fifo_dc_read_port #(.WIDTH(32), .DEPTH(DEPTH), .CNTW(4)) u4 (
    .clock(clock), .reset(reset), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
    .fifo_rdreq(rq4), .out_data(d4), .out_valid(v4),
    .out_ready(out_ready), .occupancy(o4), .words_read(wr4));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    src.push_back(w);
    fifo_rdempty = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the FIFO and buffer model past the edge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clock);
    last_rq = fifo_rdreq;
    last_v = out_valid;
    last_d = out_data;
    last_pop = out_valid && out_ready;
    chk("rdreq", fifo_rdreq, !reset && !fifo_rdempty && (occ + pres) < DEPTH);
    chk("valid", out_valid, occ != 0);
    chk("occ", occupancy, occ);
    chk("words_read", words_read, pops);
    chk("words_read4", wr4, pops % 16);
    if (last_pop) begin
      e = exq.size() != 0 ? exq.pop_front() : 'x;
      chk("data", out_data, e);
      pops++;
    end
    @(posedge clock);
    #1;
    if (reset) begin
      occ = 0; pres = 0; pops = 0;
      exq.delete(); src.delete();
    end else begin
      occ = occ + pres - int'(last_pop);
      pres = last_rq;
      if (last_rq && src.size() != 0) begin
        fifo_q = src.pop_front();
        exq.push_back(fifo_q);
      end
    end
    fifo_rdempty = src.size() == 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((occ != 0 || pres != 0 || src.size() != 0) && n < lim) begin
      cycle();
      n++;
    end
    chk("drain_in_time", n < lim, 1);
  endtask

  initial begin
    int nrq, pushed, n;
    repeat (2) @(posedge clock);
    #1;
    cycle();
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    reset = 0;
    // Three words, consumer always ready.
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("t1_rq", last_rq, c <= 2);
      chk("t1_v", last_v, c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) chk("t1_d", last_d, 32'h11 * (c - 1));
    end
    chk("t1_cnt", words_read, 3);
    chk("t1_occ", occupancy, 0);
    // Backpressure with ten words queued.
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 10; i++) push_word(32'h100 + i);
    nrq = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      nrq += int'(last_rq);
      if (last_v) chk("t2_hold", last_d, 32'h100);
    end
    chk("t2_rq_pulses", nrq, 3);
    chk("t2_rq_off", last_rq, 0);
    chk("t2_occ", occupancy, 3);
    chk("t2_head", out_data, 32'h100);
    out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("t2_stream", last_pop, 1);
    end
    chk("t2_cnt", words_read, 10);
    // Long gapless stream.
    do_reset();
    for (int i = 0; i < 100; i++) push_word(32'h5000 + i);
    cycle(); cycle();
    chk("t3_lat", last_v, 0);
    for (int c = 0; c < 100; c++) begin
      cycle();
      chk("t3_v", last_v, 1);
    end
    cycle();
    chk("t3_end", last_v, 0);
    chk("t3_cnt", words_read, 100);
    // Narrow counter wraps after 16 pops.
    do_reset();
    for (int i = 0; i < 16; i++) push_word(32'h700 + i);
    drain(100);
    chk("t5_wrap", wr4, 0);
    chk("t5_cnt", words_read, 16);
    // Reset while two words are buffered and one is in flight.
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 10; i++) push_word(32'h900 + i);
    n = 0;
    while (!(occ == 2 && pres == 1) && n < 20) begin
      cycle();
      n++;
    end
    chk("t6_reached", n < 20, 1);
    do_reset();
    cycle();
    chk("t6_v", last_v, 0);
    chk("t6_occ", occupancy, 0);
    chk("t6_cnt", words_read, 0);
    chk("t6_rq", last_rq, 0);
    chk("t6_data", last_d, 0);
    out_ready = 1;
    for (int i = 0; i < 5; i++) push_word(32'hA00 + i);
    drain(50);
    chk("t6_after", words_read, 5);
    // Random fill and random backpressure.
    do_reset();
    pushed = 0;
    n = 0;
    while (pops < 10000 && n < 80000) begin
      if (pushed < 10000 && $urandom_range(3) != 0) begin
        push_word($urandom);
        pushed++;
      end
      out_ready = $urandom_range(1);
      cycle();
      n++;
    end
    chk("t4_count", pops, 10000);
    chk("t4_left", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
